dht11_sensor_emu: RTL and testbench

DHT11_SENSOR_EMU -- requirements
Module: dht11_sensor_emu

---
 rtl/dht11_sensor_emu.sv | 156 +++++++++++++++
 tb/tb_dht11_sensor_emu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: DHT11 sensor emulator answering host start requests with a 40-bit humidity/temperature frame.
// Optional macro DHT_CRC_INJECT_EN adds CRC_ERR, which sends the inverted checksum.
module dht11_sensor_emu #(
  parameter int T_START_MIN = 1800000,
  parameter int T_RESP_DLY  = 3000,
  parameter int T_RESP_LOW  = 8000,
  parameter int T_RESP_HIGH = 8000,
  parameter int T_BIT_LOW   = 5000,
  parameter int T_BIT0_HIGH = 2700,
  parameter int T_BIT1_HIGH = 7000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  inout  wire        DHT_DATA,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
`ifdef DHT_CRC_INJECT_EN
  input  logic       CRC_ERR,
`endif
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] FRAME_CNT
);
  localparam int M1 = T_START_MIN > T_RESP_DLY ? T_START_MIN : T_RESP_DLY;
  localparam int M2 = M1 > T_RESP_LOW ? M1 : T_RESP_LOW;
  localparam int M3 = M2 > T_RESP_HIGH ? M2 : T_RESP_HIGH;
  localparam int M4 = M3 > T_BIT_LOW ? M3 : T_BIT_LOW;
  localparam int M5 = M4 > T_BIT0_HIGH ? M4 : T_BIT0_HIGH;
  localparam int M6 = M5 > T_BIT1_HIGH ? M5 : T_BIT1_HIGH;
  localparam int CW = $clog2(M6 + 1);
  localparam logic [CW-1:0] N_START = CW'(T_START_MIN - 1);
  localparam logic [CW-1:0] N_DLY   = CW'(T_RESP_DLY - 1);
  localparam logic [CW-1:0] N_RLOW  = CW'(T_RESP_LOW - 1);
  localparam logic [CW-1:0] N_RHIGH = CW'(T_RESP_HIGH - 1);
  localparam logic [CW-1:0] N_BLOW  = CW'(T_BIT_LOW - 1);
  localparam logic [CW-1:0] N_B0    = CW'(T_BIT0_HIGH - 1);
  localparam logic [CW-1:0] N_B1    = CW'(T_BIT1_HIGH - 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_REL, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [5:0]    bit_q, bit_d;
  logic [39:0]   sr_q, sr_d;
  logic [7:0]    frame_q, frame_d, crc, crc_tx;
  logic [1:0]    sync_q;
  logic          drive_q, drive_d, busy_q, busy_d, done_q, done_d, line_s, tc;

  assign line_s = sync_q[1];
  assign crc    = HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT;
`ifdef DHT_CRC_INJECT_EN
  assign crc_tx = CRC_ERR ? ~crc : crc;
`else
  assign crc_tx = crc;
`endif

  // Each timed state lasts exactly lim+1 cycles; the drive flop tracks state_q one-for-one.
  assign lim = state_q == START_LOW ? N_START :
               state_q == RESP_DLY  ? N_DLY   :
               state_q == RESP_LOW  ? N_RLOW  :
               state_q == RESP_HIGH ? N_RHIGH :
               state_q == BIT_HIGH  ? (sr_q[39] ? N_B1 : N_B0) : N_BLOW;
  assign tc  = cnt_q == lim;

  always_comb begin
    state_d = state_q;
    cnt_d   = tc ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line_s) state_d = START_LOW;
      end
      START_LOW: begin
        if (line_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tc) begin
          state_d = WAIT_REL;
          sr_d    = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, crc_tx};
        end
      end
      WAIT_REL: begin
        cnt_d = '0;
        if (line_s) state_d = RESP_DLY;
      end
      RESP_DLY:  if (tc) state_d = RESP_LOW;
      RESP_LOW:  if (tc) state_d = RESP_HIGH;
      RESP_HIGH: if (tc) state_d = BIT_LOW;
      BIT_LOW:   if (tc) state_d = BIT_HIGH;
      BIT_HIGH: begin
        if (tc) begin
          state_d = bit_q == 6'd39 ? END_LOW : BIT_LOW;
          bit_d   = bit_q + 1'b1;
          sr_d    = {sr_q[38:0], 1'b0};
        end
      end
      END_LOW: begin
        if (tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      sr_d    = '0;
      done_d  = 1'b0;
    end
  end

  assign drive_d = state_d == RESP_LOW || state_d == BIT_LOW || state_d == END_LOW;
  assign busy_d  = state_d != IDLE && state_d != START_LOW;
  assign frame_d = frame_q + {7'b0, done_d};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      frame_q <= '0;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      frame_q <= frame_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // Our own end-of-frame low is still in the synchronizer; treat the released line as high.
      sync_q  <= done_d ? 2'b11 : {sync_q[0], DHT_DATA};
    end
  end

  assign DHT_DATA  = drive_q ? 1'b0 : 1'bz;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FRAME_CNT = frame_q;
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: host-side bench that issues start requests and decodes the frame from pulse widths.
module tb_dht11_sensor_emu;
  localparam int TS = 40, TD = 6, TRL = 10, TRH = 12, TBL = 5, TB0 = 3, TB1 = 8;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, host_low = 1'b0;
  logic [7:0] hi = '0, hf = '0, ti = '0, tf = '0;
`ifdef DHT_CRC_INJECT_EN
  logic crc_err = 1'b0;
`endif
  wire dht;
  logic busy, done;
  logic [7:0] fcnt;
  int errs = 0, checks = 0, done_seen = 0;
  logic [7:0] exp_fc = '0;

  pullup (dht);
  assign dht = host_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  dht11_sensor_emu #(
    .T_START_MIN(TS), .T_RESP_DLY(TD), .T_RESP_LOW(TRL), .T_RESP_HIGH(TRH),
    .T_BIT_LOW(TBL), .T_BIT0_HIGH(TB0), .T_BIT1_HIGH(TB1)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .DHT_DATA(dht),
    .HUM_INT(hi), .HUM_FLOAT(hf), .TEMP_INT(ti), .TEMP_FLOAT(tf),
`ifdef DHT_CRC_INJECT_EN
    .CRC_ERR(crc_err),
`endif
    .BUSY(busy), .DONE(done), .FRAME_CNT(fcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi_v);
    checks++;
    assert (obs >= lo && obs <= hi_v) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi_v);
    end
  endtask

  // Count consecutive negedge samples at level lvl; ends on the first sample that differs.
  task automatic width(input logic lvl, output int n);
    n = 0;
    while (dht === lvl && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic idle_watch(input string tag, input int cyc);
    int bad = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (dht !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic short_low(input string tag, input int n);
    int bad = 0;
    host_low = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    host_low = 1'b0;
    check({tag, "_busy_low"}, bad, 0);
    idle_watch({tag, "_no_resp"}, 3 * TS);
    check({tag, "_fcnt"}, fcnt, exp_fc);
  endtask

  // mode 0: full frame, 1: reset during bit 'at' low, 2: payload change at bit 'at', 3: EN drop in response high
  task automatic frame(input logic [7:0] a, b, c, d, input int mode, input int at);
    logic [39:0] exp_bits, got;
    int n, bad, d0;
    exp_bits = {a, b, c, d, 8'(a + b + c + d)};
`ifdef DHT_CRC_INJECT_EN
    if (crc_err) exp_bits[7:0] = ~exp_bits[7:0];
`endif
    hi = a; hf = b; ti = c; tf = d;
    got = '0; bad = 0; d0 = done_seen;
    host_low = 1'b1;
    repeat (TS + TS / 2) @(negedge clk);
    host_low = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    width(1'b1, n);
    check_rng("resp_delay", n, TD, TD + 3);
    width(1'b0, n);
    check("resp_low", n, TRL);
    if (mode == 3) begin
      repeat (3) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("en_busy_clr", busy, 1'b0);
      repeat (9) @(negedge clk);
      check("en_released", dht, 1'b1);
      en = 1'b1;
      @(negedge clk);
      check("en_no_done", done_seen, d0);
      check("en_fcnt_held", fcnt, exp_fc);
      return;
    end
    width(1'b1, n);
    check("resp_high", n, TRH);
    for (int i = 0; i < 40; i++) begin
      if (mode == 2 && i == at) begin
        hi = '0; hf = '0; ti = '0; tf = '0;
      end
      if (mode == 1 && i == at) begin
        @(negedge clk);
        check("bit_low_before_rst", dht, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_released", dht, 1'b1);
        check("rst_fcnt", fcnt, 8'h00);
        check("rst_busy", busy, 1'b0);
        exp_fc = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", done_seen, d0);
        return;
      end
      width(1'b0, n);
      if (n != TBL) bad++;
      width(1'b1, n);
      if (n != TB0 && n != TB1) bad++;
      got = {got[38:0], n == TB1};
    end
    check("bit_widths_bad", bad, 0);
    check("frame_bits", got, exp_bits);
    width(1'b0, n);
    check("end_low", n, TBL);
    exp_fc = exp_fc + 8'd1;
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("frame_cnt", fcnt, exp_fc);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("done_count", done_seen, d0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r [4];
    repeat (3) @(negedge clk);
    check("rst_line", dht, 1'b1);
    check("rst_busy0", busy, 1'b0);
    check("rst_done0", done, 1'b0);
    check("rst_fcnt0", fcnt, 8'h00);
    rst = 1'b0;
    idle_watch("idle_after_rst", 10);
    frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0);
    idle_watch("no_restart_after_frame", 2 * TS);
    short_low("short_half", TS / 2);
    short_low("short_near", TS - 5);
    short_low("glitch", 2);
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 5);
    for (int k = 0; k < 3; k++) begin
      foreach (r[j]) r[j] = 8'($urandom);
      frame(r[0], r[1], r[2], r[3], 0, 0);
    end
    foreach (r[j]) r[j] = 8'($urandom);
    frame(r[0], r[1], r[2], r[3], 1, 20);
    idle_watch("idle_after_midrst", 2 * TS);
    foreach (r[j]) r[j] = 8'($urandom);
    frame(r[0], r[1], r[2], r[3], 0, 0);
    foreach (r[j]) r[j] = 8'($urandom);
    frame(r[0], r[1], r[2], r[3], 3, 0);
    idle_watch("idle_after_en", 2 * TS);
    foreach (r[j]) r[j] = 8'($urandom);
    frame(r[0], r[1], r[2], r[3], 0, 0);
`ifdef DHT_CRC_INJECT_EN
    crc_err = 1'b1;
    frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0);
    crc_err = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
